// File: rtl/m68k_bus_seq.sv
// 68000-style asynchronous bus master: runs one read/write cycle per accepted command.
// Latency: accept -> rsp_valid is 6 cycles (read) / 7 (write) once dtack is seen, plus synchronizer delay.
// Backpressure: cmd_ready only in IDLE with the synchronized dtack high; responder stalls via dtack.
module m68k_bus_seq #(
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk40,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [23:0] cmd_addr,
   input  logic [2:0]  cmd_fc,
   input  logic        cmd_rw,
   input  logic        cmd_byte,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic [22:0] bus_a,
   output logic [2:0]  bus_fc,
   output logic        bus_rw,
   output logic        bus_as_n,
   output logic        bus_uds_n,
   output logic        bus_lds_n,
   output logic [15:0] bus_dout,
   output logic        bus_doe,
   input  logic [15:0] bus_din,
   input  logic        bus_dtack_n,
   input  logic        bus_berr_n
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ADDR, ASRT, DSW, WAIT, LATCH, NEG, RSP} state_t;

   state_t state, state_nxt;

   // latched command
   logic [23:0] addr_q;
   logic [2:0]  fc_q;
   logic        rw_q;
   logic        byte_q;
   logic [15:0] wdata_q;

   logic [SYNC_STAGES-1:0] dtack_sync;
   logic [SYNC_STAGES-1:0] berr_sync;
   logic        dtack_s;
   logic        berr_s;

   logic [CW-1:0] cnt;
   logic        timeout_hit;
   logic [1:0]  err_q;
   logic [15:0] rdata_q;
   logic        data_strb;
   logic        uds_en;
   logic        lds_en;

   assign dtack_s     = dtack_sync[SYNC_STAGES-1];
   assign berr_s      = berr_sync[SYNC_STAGES-1];
   assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

   // byte lanes: even byte address lives on the upper lane (D15..D8)
   assign uds_en = !byte_q || !addr_q[0];
   assign lds_en = !byte_q ||  addr_q[0];

   assign bus_a    = addr_q[23:1];
   assign bus_fc   = fc_q;
   assign bus_dout = wdata_q;

   // bring the asynchronous handshake inputs into the clk40 domain
   always_ff @(posedge clk40 or negedge reset_n) begin
      if (!reset_n) begin
         dtack_sync <= '1;
         berr_sync  <= '1;
      end else begin
         dtack_sync[0] <= bus_dtack_n;
         berr_sync[0]  <= bus_berr_n;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            dtack_sync[i] <= dtack_sync[i-1];
            berr_sync[i]  <= berr_sync[i-1];
         end
      end
   end

   // state register
   always_ff @(posedge clk40 or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state and bus strobe decode
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      bus_rw    = 1'b1;
      bus_as_n  = 1'b1;
      bus_doe   = 1'b0;
      data_strb = 1'b0;
      bus_uds_n = 1'b1;
      bus_lds_n = 1'b1;
      case (state)
         IDLE: begin
            // a responder still holding dtack from the last cycle blocks the next one
            cmd_ready = dtack_s;
            if (cmd_valid && dtack_s) state_nxt = ADDR;
         end
         ADDR: begin
            bus_rw    = rw_q;
            state_nxt = ASRT;
         end
         ASRT: begin
            bus_rw   = rw_q;
            bus_as_n = 1'b0;
            if (rw_q) begin
               data_strb = 1'b1;
               state_nxt = WAIT;
            end else begin
               bus_doe   = 1'b1;
               state_nxt = DSW;
            end
         end
         DSW: begin
            bus_rw    = rw_q;
            bus_as_n  = 1'b0;
            bus_doe   = 1'b1;
            data_strb = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            bus_rw    = rw_q;
            bus_as_n  = 1'b0;
            bus_doe   = !rw_q;
            data_strb = 1'b1;
            if (!berr_s || !dtack_s || timeout_hit) state_nxt = LATCH;
         end
         LATCH: begin
            bus_rw    = rw_q;
            bus_as_n  = 1'b0;
            bus_doe   = !rw_q;
            data_strb = 1'b1;
            state_nxt = NEG;
         end
         NEG: begin
            bus_rw    = rw_q;
            bus_doe   = !rw_q;
            state_nxt = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (data_strb) begin
         bus_uds_n = !uds_en;
         bus_lds_n = !lds_en;
      end
   end

   // command capture, wait counter, status and read data
   always_ff @(posedge clk40 or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= '0;
         fc_q      <= '0;
         rw_q      <= 1'b1;
         byte_q    <= 1'b0;
         wdata_q   <= '0;
         cnt       <= '0;
         err_q     <= 2'b00;
         rdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 2'b00;
      end else begin
         if (state == IDLE && cmd_valid && dtack_s) begin
            addr_q  <= cmd_addr;
            fc_q    <= cmd_fc;
            rw_q    <= cmd_rw;
            byte_q  <= cmd_byte;
            wdata_q <= cmd_byte ? {cmd_wdata[7:0], cmd_wdata[7:0]} : cmd_wdata;
         end
         // counter runs only while waiting, so it is zero on every WAIT entry
         if (state == WAIT) cnt <= cnt + CW'(1);
         else               cnt <= '0;
         // berr outranks dtack when both arrive together
         if (state == WAIT) begin
            if (!berr_s)           err_q <= 2'b01;
            else if (!dtack_s)     err_q <= 2'b00;
            else if (timeout_hit)  err_q <= 2'b10;
         end
         if (state == LATCH) begin
            if (rw_q && err_q == 2'b00) begin
               if (byte_q) rdata_q <= {8'h00, addr_q[0] ? bus_din[7:0] : bus_din[15:8]};
               else        rdata_q <= bus_din;
            end else begin
               rdata_q <= '0;
            end
         end
         // response fields change only together with the rsp_valid pulse
         if (state == NEG) begin
            rsp_rdata <= rdata_q;
            rsp_err   <= err_q;
         end
      end
   end

endmodule

// File: tb/tb_m68k_bus_seq.sv
// Directed bench for m68k_bus_seq with a behavioural 68000 slave responder.
// Latency: n/a (bench). Backpressure: responder delays/holds dtack per test.
// Expected values below are worked out by hand from the bus cycle timing.
module tb_m68k_bus_seq;

   logic        clk40 = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_addr;
   logic [2:0]  cmd_fc;
   logic        cmd_rw;
   logic        cmd_byte;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic [22:0] bus_a;
   logic [2:0]  bus_fc;
   logic        bus_rw;
   logic        bus_as_n;
   logic        bus_uds_n;
   logic        bus_lds_n;
   logic [15:0] bus_dout;
   logic        bus_doe;
   logic [15:0] bus_din     = 16'h0000;
   logic        bus_dtack_n = 1'b1;
   logic        bus_berr_n  = 1'b1;

   always #5 clk40 = ~clk40;

   m68k_bus_seq #(.TIMEOUT(15), .SYNC_STAGES(2)) dut (
      .clk40(clk40), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_fc(cmd_fc),
      .cmd_rw(cmd_rw), .cmd_byte(cmd_byte), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bus_a(bus_a), .bus_fc(bus_fc), .bus_rw(bus_rw), .bus_as_n(bus_as_n),
      .bus_uds_n(bus_uds_n), .bus_lds_n(bus_lds_n), .bus_dout(bus_dout), .bus_doe(bus_doe),
      .bus_din(bus_din), .bus_dtack_n(bus_dtack_n), .bus_berr_n(bus_berr_n)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // responder: mode 0 = silent, 1 = dtack, 2 = berr+dtack together
   int          mode = 1;
   int          dly  = 2;
   int          hold = 0;
   logic        din_from_addr = 1'b0;
   logic [15:0] din_val = 16'h0000;
   int          acnt = 0;
   int          hcnt = 0;

   always @(posedge clk40) begin
      #1;
      if (!bus_as_n) begin
         hcnt = 0;
         acnt++;
         if (mode != 0 && acnt >= dly) begin
            bus_dtack_n = 1'b0;
            if (mode == 2) bus_berr_n = 1'b0;
            bus_din = din_from_addr ? (bus_a[15:0] ^ 16'h5A5A) : din_val;
         end
      end else begin
         acnt = 0;
         if (hcnt >= hold) begin
            bus_dtack_n = 1'b1;
            bus_berr_n  = 1'b1;
         end else begin
            hcnt++;
         end
      end
   end

   // response log and address-strobe gap tracking
   int          rsp_cnt = 0;
   logic [15:0] rsp_log [64];
   int          hi_run  = 0;
   int          min_gap = 99;
   logic        gap_en  = 1'b0;
   logic        gap_prev = 1'b0;

   always @(posedge clk40) begin
      #1;
      if (rsp_valid) begin
         if (rsp_cnt < 64) rsp_log[rsp_cnt] = rsp_rdata;
         rsp_cnt++;
      end
      if (bus_as_n) begin
         hi_run++;
      end else begin
         if (hi_run > 0 && gap_en) begin
            if (gap_prev && hi_run < min_gap) min_gap = hi_run;
            gap_prev = 1'b1;
         end
         hi_run = 0;
      end
   end

   // per-command observations
   int          lat, as_first, ds_first, as_low_cnt;
   logic        uds_low, lds_low, doe_seen, rw_seen, got_rsp, got_ready, after_v;
   logic [22:0] a_seen;
   logic [2:0]  fc_seen;
   logic [15:0] dout_seen, r_rdata;
   logic [1:0]  r_err;
   logic        r_as, r_uds, r_lds, r_doe;

   task automatic issue(input logic [23:0] a, input logic [2:0] fc, input logic rw,
                        input logic by, input logic [15:0] wd);
      cmd_addr  = a;
      cmd_fc    = fc;
      cmd_rw    = rw;
      cmd_byte  = by;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      got_ready = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready) begin
            got_ready = 1'b1;
            break;
         end
         @(posedge clk40); #1;
      end
      chk("accept", got_ready, 1);
      @(posedge clk40); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic [23:0] a, input logic [2:0] fc, input logic rw,
                          input logic by, input logic [15:0] wd);
      issue(a, fc, rw, by, wd);
      lat = 0; as_first = 0; ds_first = 0; as_low_cnt = 0;
      uds_low = 0; lds_low = 0; doe_seen = 0; rw_seen = 1; got_rsp = 0;
      a_seen = '0; fc_seen = '0; dout_seen = '0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk40); #1;
         lat++;
         if (!bus_as_n) begin
            as_low_cnt++;
            if (as_first == 0) as_first = lat;
            a_seen  = bus_a;
            fc_seen = bus_fc;
            rw_seen = bus_rw;
         end
         if ((!bus_uds_n || !bus_lds_n) && ds_first == 0) ds_first = lat;
         uds_low = uds_low | !bus_uds_n;
         lds_low = lds_low | !bus_lds_n;
         if (bus_doe) begin
            doe_seen  = 1'b1;
            dout_seen = bus_dout;
         end
         if (rsp_valid) begin
            got_rsp = 1'b1;
            r_rdata = rsp_rdata;
            r_err   = rsp_err;
            r_as    = bus_as_n;
            r_uds   = bus_uds_n;
            r_lds   = bus_lds_n;
            r_doe   = bus_doe;
            break;
         end
      end
      chk("rsp_seen", got_rsp, 1);
      @(posedge clk40); #1;
      after_v = rsp_valid;
   endtask

   logic [23:0] b2b_addr [4] = '{24'h000100, 24'h000202, 24'h000304, 24'h000406};
   logic [15:0] b2b_exp  [4] = '{16'h5ADA, 16'h5B5B, 16'h5BD8, 16'h5859};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n, save;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_fc = '0;
      cmd_rw = 1'b1; cmd_byte = 1'b0; cmd_wdata = '0;
      repeat (3) @(posedge clk40);
      #1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_as", bus_as_n, 1);
      chk("rst_uds", bus_uds_n, 1);
      chk("rst_lds", bus_lds_n, 1);
      chk("rst_rw", bus_rw, 1);
      chk("rst_doe", bus_doe, 0);
      chk("rst_a", bus_a, 0);
      chk("rst_fc", bus_fc, 0);
      chk("rst_dout", bus_dout, 0);
      reset_n = 1'b1;
      @(posedge clk40); #1;

      // word read, dtack two cycles after as_n
      mode = 1; dly = 2; din_val = 16'h1234;
      run_cmd(24'h000F08, 3'd5, 1'b1, 1'b0, 16'h0000);
      chk("wr_lat", lat, 7);
      chk("wr_as_first", as_first, 1);
      chk("wr_ds_first", ds_first, 1);
      chk("wr_as_cycles", as_low_cnt, 5);
      chk("wr_uds", uds_low, 1);
      chk("wr_lds", lds_low, 1);
      chk("wr_a", a_seen, 23'h000784);
      chk("wr_fc", fc_seen, 5);
      chk("wr_rw", rw_seen, 1);
      chk("wr_doe", doe_seen, 0);
      chk("wr_rdata", r_rdata, 16'h1234);
      chk("wr_err", r_err, 0);
      chk("wr_pulse_end", after_v, 0);
      chk("wr_rdata_hold", rsp_rdata, 16'h1234);
      chk("wr_ready_after", cmd_ready, 1);

      // byte write to odd address: lower lane, data replicated
      run_cmd(24'h001801, 3'd5, 1'b0, 1'b1, 16'h0034);
      chk("bw_lat", lat, 7);
      chk("bw_as_first", as_first, 1);
      chk("bw_ds_first", ds_first, 2);
      chk("bw_uds", uds_low, 0);
      chk("bw_lds", lds_low, 1);
      chk("bw_dout", dout_seen, 16'h3434);
      chk("bw_doe", doe_seen, 1);
      chk("bw_rw", rw_seen, 0);
      chk("bw_a", a_seen, 23'h000C00);
      chk("bw_rsp_doe", r_doe, 0);
      chk("bw_rdata", r_rdata, 0);
      chk("bw_err", r_err, 0);

      // byte reads: odd -> D7..D0, even -> D15..D8
      din_val = 16'hABCD;
      run_cmd(24'h000311, 3'd1, 1'b1, 1'b1, 16'h0000);
      chk("br_odd_rdata", r_rdata, 16'h00CD);
      chk("br_odd_uds", uds_low, 0);
      chk("br_odd_lds", lds_low, 1);
      run_cmd(24'h000310, 3'd1, 1'b1, 1'b1, 16'h0000);
      chk("br_even_rdata", r_rdata, 16'h00AB);
      chk("br_even_uds", uds_low, 1);
      chk("br_even_lds", lds_low, 0);

      // bus error with dtack on the same edge
      mode = 2; din_val = 16'hBEEF;
      run_cmd(24'h000200, 3'd6, 1'b1, 1'b0, 16'h0000);
      chk("be_lat", lat, 7);
      chk("be_err", r_err, 2'b01);
      chk("be_rdata", r_rdata, 0);

      // timeout: ASRT + 15 WAIT + LATCH with as_n low
      mode = 0;
      run_cmd(24'h000400, 3'd5, 1'b1, 1'b0, 16'h0000);
      chk("to_lat", lat, 19);
      chk("to_as_cycles", as_low_cnt, 17);
      chk("to_err", r_err, 2'b10);
      chk("to_rdata", r_rdata, 0);
      chk("to_as_rsp", r_as, 1);
      chk("to_uds_rsp", r_uds, 1);
      chk("to_lds_rsp", r_lds, 1);

      // responder holds dtack long after as_n: next cycle must wait
      mode = 1; dly = 1; hold = 6; din_val = 16'h0F0F;
      run_cmd(24'h000500, 3'd5, 1'b1, 1'b0, 16'h0000);
      chk("hd_lat", lat, 6);
      chk("hd_rdata", r_rdata, 16'h0F0F);
      chk("hd_ready_low", cmd_ready, 0);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk40); #1;
         n++;
         if (cmd_ready) break;
      end
      chk("hd_ready_wait", n, 6);
      hold = 0; dly = 2;

      // back-to-back reads with cmd_valid held
      din_from_addr = 1'b1; gap_en = 1'b1; gap_prev = 1'b0; min_gap = 99;
      base = rsp_cnt;
      cmd_rw = 1'b1; cmd_byte = 1'b0; cmd_fc = 3'd1; cmd_wdata = '0;
      for (int k = 0; k < 4; k++) begin
         cmd_addr  = b2b_addr[k];
         cmd_valid = 1'b1;
         got_ready = 1'b0;
         for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
               got_ready = 1'b1;
               break;
            end
            @(posedge clk40); #1;
         end
         chk("b2b_accept", got_ready, 1);
         @(posedge clk40); #1;
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (rsp_cnt - base >= 4) break;
         @(posedge clk40); #1;
      end
      repeat (10) @(posedge clk40);
      #1;
      chk("b2b_count", rsp_cnt - base, 4);
      for (int k = 0; k < 4; k++) chk("b2b_rdata", rsp_log[base + k], b2b_exp[k]);
      chk("b2b_min_gap", min_gap, 4);
      gap_en = 1'b0; din_from_addr = 1'b0;

      // reset in the middle of WAIT
      mode = 0;
      issue(24'h000600, 3'd5, 1'b1, 1'b0, 16'h0000);
      repeat (4) @(posedge clk40);
      #1;
      chk("mw_in_cycle", bus_as_n, 0);
      save = rsp_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mw_as", bus_as_n, 1);
      chk("mw_uds", bus_uds_n, 1);
      chk("mw_lds", bus_lds_n, 1);
      chk("mw_rsp_valid", rsp_valid, 0);
      chk("mw_ready", cmd_ready, 1);
      repeat (2) @(posedge clk40);
      #1;
      reset_n = 1'b1;
      repeat (20) @(posedge clk40);
      #1;
      chk("mw_no_rsp", rsp_cnt - save, 0);
      mode = 1; din_val = 16'h1234;
      run_cmd(24'h000F08, 3'd5, 1'b1, 1'b0, 16'h0000);
      chk("mw_next_lat", lat, 7);
      chk("mw_next_rdata", r_rdata, 16'h1234);
      chk("mw_next_err", r_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
